// File: rtl/mux_2x1_arbiter.sv
// Round-robin arbiter for two requesters sharing a 2:1 mux. The grant state drives
// the select, and the selected word is registered with a valid tag.
module mux_2x1_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic [DATA_WIDTH-1:0] I0,
  input  logic [DATA_WIDTH-1:0] I1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  SEL,
  output logic [DATA_WIDTH-1:0] OUT,
  output logic                  OUT_VALID
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [BW-1:0]           burst_cnt_q, burst_cnt_d;
  logic                    last_q, last_d;
  logic                    sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    transfer;

  always_comb begin
    state_d  = state_q;
    transfer = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie, the side that was not granted last wins.
        if (REQ0 && REQ1)  state_d = last_q ? GRANT0 : GRANT1;
        else if (REQ0)     state_d = GRANT0;
        else if (REQ1)     state_d = GRANT1;
      end
      GRANT0: begin
        transfer = REQ0;
        if (!REQ0)                                   state_d = REQ1 ? GRANT1 : IDLE;
        else if (burst_cnt_q == BURST_LAST && REQ1)  state_d = GRANT1;
      end
      GRANT1: begin
        transfer = REQ1;
        if (!REQ1)                                   state_d = REQ0 ? GRANT0 : IDLE;
        else if (burst_cnt_q == BURST_LAST && REQ0)  state_d = GRANT0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    last_d      = last_q;
    sel_d       = sel_q;
    out_d       = out_q;
    out_valid_d = transfer;
    // The count saturates one short of the limit so a late request from the other side switches on the next transfer.
    if (state_d != state_q)                          burst_cnt_d = '0;
    else if (transfer && burst_cnt_q != BURST_LAST)  burst_cnt_d = burst_cnt_q + BW'(1);
    if (state_d == GRANT0) begin
      last_d = 1'b0;
      sel_d  = 1'b0;
    end else if (state_d == GRANT1) begin
      last_d = 1'b1;
      sel_d  = 1'b1;
    end
    if (transfer) out_d = sel_q ? I1 : I0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign GNT0      = (state_q == GRANT0);
  assign GNT1      = (state_q == GRANT1);
  assign SEL       = sel_q;
  assign OUT       = out_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Directed bench for mux_2x1_arbiter: one instance with MAX_BURST=4 and one with
// MAX_BURST=1, driven by shared inputs.
module tb_mux_2x1_arbiter;

  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, req0, req1;
  logic [DW-1:0] i0, i1;
  logic          gnt0_a, gnt1_a, sel_a, valid_a;
  logic [DW-1:0] out_a;
  logic          gnt0_b, gnt1_b, sel_b, valid_b;
  logic [DW-1:0] out_b;

  int testsRun    = 0;
  int testsFailed = 0;

  mux_2x1_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .CLK(clk), .RSTn(rst_n), .REQ0(req0), .REQ1(req1), .I0(i0), .I1(i1),
    .GNT0(gnt0_a), .GNT1(gnt1_a), .SEL(sel_a), .OUT(out_a), .OUT_VALID(valid_a)
  );

  mux_2x1_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(1)) dut1 (
    .CLK(clk), .RSTn(rst_n), .REQ0(req0), .REQ1(req1), .I0(i0), .I1(i1),
    .GNT0(gnt0_b), .GNT1(gnt1_b), .SEL(sel_b), .OUT(out_b), .OUT_VALID(valid_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req0 = r0;
    req1 = r1;
    i0   = d0;
    i1   = d1;
  endtask

  // Outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 4'd3, 4'd9);
    repeat (3) tick;
    checkOutput("rst_gnt0", 32'(gnt0_a), 0);
    checkOutput("rst_gnt1", 32'(gnt1_a), 0);
    checkOutput("rst_out", 32'(out_a), 0);
    checkOutput("rst_valid", 32'(valid_a), 0);
    checkOutput("rst_sel", 32'(sel_a), 0);
    checkOutput("rst_gnt0_b", 32'(gnt0_b), 0);

    // Contention: 4-cycle bursts on dut, strict alternation on dut1.
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick;
      checkOutput($sformatf("cont_gnt0_k%0d", k), 32'(gnt0_a), 32'(((k / 4) % 2) == 0));
      checkOutput($sformatf("cont_gnt1_k%0d", k), 32'(gnt1_a), 32'(((k / 4) % 2) == 1));
      checkOutput($sformatf("cont_sel_k%0d", k), 32'(sel_a), 32'(((k / 4) % 2) == 1));
      checkOutput($sformatf("cont_both_k%0d", k), 32'(gnt0_a & gnt1_a), 0);
      checkOutput($sformatf("cont_valid_k%0d", k), 32'(valid_a), 32'(k >= 1));
      if (k >= 1)
        checkOutput($sformatf("cont_out_k%0d", k), 32'(out_a), (((k - 1) / 4) % 2 == 0) ? 3 : 9);
      checkOutput($sformatf("alt_gnt0_k%0d", k), 32'(gnt0_b), 32'((k % 2) == 0));
      checkOutput($sformatf("alt_gnt1_k%0d", k), 32'(gnt1_b), 32'((k % 2) == 1));
      if (k >= 1)
        checkOutput($sformatf("alt_out_k%0d", k), 32'(out_b), (((k - 1) % 2) == 0) ? 3 : 9);
    end

    // dut is in GRANT1 here; reset between edges must clear outputs at once.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_gnt1", 32'(gnt1_a), 0);
    checkOutput("async_sel", 32'(sel_a), 0);
    checkOutput("async_out", 32'(out_a), 0);
    checkOutput("async_valid", 32'(valid_a), 0);

    // Single requester.
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
    tick;
    rst_n = 1'b1;
    tick;
    applyStimulus(1'b1, 1'b0, 4'd5, 4'd0);
    checkOutput("single_c0_gnt0", 32'(gnt0_a), 0);
    tick;
    checkOutput("single_c1_gnt0", 32'(gnt0_a), 1);
    checkOutput("single_c1_valid", 32'(valid_a), 0);
    for (int c = 2; c <= 3; c++) begin
      tick;
      checkOutput($sformatf("single_c%0d_gnt0", c), 32'(gnt0_a), 1);
      checkOutput($sformatf("single_c%0d_valid", c), 32'(valid_a), 1);
      checkOutput($sformatf("single_c%0d_out", c), 32'(out_a), 5);
      checkOutput($sformatf("single_c%0d_gnt0_b", c), 32'(gnt0_b), 1);
      checkOutput($sformatf("single_c%0d_out_b", c), 32'(out_b), 5);
    end
    tick;
    applyStimulus(1'b0, 1'b0, 4'd5, 4'd0);
    checkOutput("single_c4_gnt0", 32'(gnt0_a), 1);
    checkOutput("single_c4_valid", 32'(valid_a), 1);
    checkOutput("single_c4_out", 32'(out_a), 5);
    tick;
    checkOutput("single_c5_gnt0", 32'(gnt0_a), 0);
    checkOutput("single_c5_valid", 32'(valid_a), 0);
    checkOutput("single_c5_out", 32'(out_a), 5);
    checkOutput("single_c5_gnt0_b", 32'(gnt0_b), 0);

    // Early release: REQ0 drops after two transfers while REQ1 waits.
    applyStimulus(1'b1, 1'b0, 4'd3, 4'd0);
    tick;
    checkOutput("early_c6_gnt0", 32'(gnt0_a), 1);
    applyStimulus(1'b1, 1'b1, 4'd3, 4'd9);
    tick;
    checkOutput("early_c7_gnt0", 32'(gnt0_a), 1);
    checkOutput("early_c7_out", 32'(out_a), 3);
    tick;
    checkOutput("early_c8_gnt0", 32'(gnt0_a), 1);
    checkOutput("early_c8_valid", 32'(valid_a), 1);
    applyStimulus(1'b0, 1'b1, 4'd3, 4'd9);
    tick;
    checkOutput("early_c9_gnt1", 32'(gnt1_a), 1);
    checkOutput("early_c9_gnt0", 32'(gnt0_a), 0);
    checkOutput("early_c9_sel", 32'(sel_a), 1);
    checkOutput("early_c9_valid", 32'(valid_a), 0);
    applyStimulus(1'b1, 1'b1, 4'd3, 4'd9);
    tick;
    checkOutput("early_c10_out", 32'(out_a), 9);
    checkOutput("early_c10_valid", 32'(valid_a), 1);
    tick;
    tick;
    checkOutput("early_c12_gnt1", 32'(gnt1_a), 1);
    tick;
    checkOutput("early_c13_gnt0", 32'(gnt0_a), 1);
    checkOutput("early_c13_gnt1", 32'(gnt1_a), 0);
    checkOutput("early_c13_out", 32'(out_a), 9);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
